lt_measure: RTL
===============

LT_MEASURE -- requirements
Module: lt_measure

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk27  in  1  27 MHz pixel/system clock; all state on its rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 trigger  in  1  synchronous level; rising edge starts a test, low aborts or releases.
REQ-005 mode_in  in  2  requested box position, LT_POS_TOPLEFT/CENTER/BOTTOMRIGHT encoding.
REQ-006 VSYNC_in  in  1  negative-polarity vsync from the video generator, synchronous to clk27.
REQ-007 sensor  in  1  asynchronous photodiode comparator, 1 = light detected.
REQ-008 lt_active  out  1  drives the video generator's box enable.
REQ-009 lt_mode  out  2  box position latched at test start.
REQ-010 lt_result  out  16  latency in microseconds, saturating at 0xFFFF.
REQ-011 lt_frames  out  8  VSYNC falling edges seen during measurement, saturating at 0xFF.
REQ-012 lt_finished  out  1  high while a completed result is held.

Function
REQ-013 sensor SHALL pass through a 2-flop synchronizer before any use; the filtered value is sens_f.
REQ-014 VSYNC falling edge SHALL be detected as a registered previous value of 1 with a current value of 0, giving a 1-cycle vs_fall pulse.
REQ-015 FSM states SHALL be IDLE, ARM, WAIT_VS, MEASURE and DONE, in that order.
REQ-016 IDLE->ARM on trigger rising edge; on ARM entry lt_result, lt_frames and the prescaler SHALL clear, and lt_mode SHALL latch mode_in.
REQ-017 ARM->WAIT_VS when sens_f==0 (screen dark); ARM SHALL wait indefinitely otherwise.
REQ-018 WAIT_VS->MEASURE on vs_fall; lt_active SHALL be 1 in MEASURE only, registered, asserting the cycle after vs_fall.
REQ-019 In MEASURE, a prescaler SHALL count 0..26; on wrap, lt_result increments (saturating), and each vs_fall increments lt_frames (saturating).
REQ-020 MEASURE->DONE on the first cycle with sens_f==1, or when lt_result reaches 0xFFFF (timeout).
REQ-021 If detection coincides with saturation, the SHALL-held value is 0xFFFF; the prescaler wrap in the detection cycle is discarded.
REQ-022 In DONE, lt_finished SHALL be 1 and results held; DONE->IDLE when trigger==0, and results SHALL stay valid in IDLE until the next ARM.
REQ-023 trigger==0 in ARM, WAIT_VS or MEASURE SHALL abort to IDLE next cycle with lt_active=0 and lt_finished=0; abort beats detection in the same cycle.
REQ-024 lt_active SHALL deassert in the cycle DONE or IDLE is entered.

Reset
REQ-025 On reset_n low, the state SHALL be IDLE and lt_active, lt_finished, lt_result, lt_frames, lt_mode, the prescaler, the synchronizer and the debounce state SHALL all be 0, asynchronously.
REQ-026 Reset mid-MEASURE SHALL drop lt_active immediately, with no result retained.

Configuration
REQ-027 With LT_SENSOR_DEBOUNCE_EN defined, sens_f SHALL change only after the synchronized sensor has held a new value for LT_DEBOUNCE_CYC (64) consecutive cycles.
REQ-028 Without LT_SENSOR_DEBOUNCE_EN, sens_f SHALL equal the synchronizer output, and no filter logic is built.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the LT_POS_* codes, LT_US_DIV=27 and LT_DEBOUNCE_CYC=64; the video generator SHALL use the same LT_POS_* codes.
REQ-030 The synchronizer plus debounce SHALL be one sub-module, lt_sensor_filter.

Verification
REQ-031 Trigger rises, sensor dark, sensor rises 27000 cycles after vs_fall -> lt_result=1000 (no macro) or 1002 (with macro), lt_finished=1, lt_frames=0 at a 16.7 ms frame.
REQ-032 Sensor never rises -> lt_result=0xFFFF, state DONE, lt_active=0 after about 65.5 ms.
REQ-033 Sensor bright at trigger -> stays in ARM and lt_active stays 0; sensor goes dark, then next vs_fall -> lt_active=1.
REQ-034 Trigger drops in MEASURE in the same cycle sens_f rises -> IDLE, lt_finished=0, lt_active=0 the next cycle.
REQ-035 With macro, 10-cycle sensor glitch in MEASURE -> no detection; without macro -> detection.
REQ-036 reset_n pulsed low mid-MEASURE -> all outputs 0 asynchronously; a new trigger after release -> normal measurement.

Source files
------------

// File: rtl/lt_measure_pkg.sv
// lt_measure_pkg: shared FSM encoding, box-position codes and timing constants for the
// latency tester and the video generator.
package lt_measure_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_VS,
        ST_MEASURE,
        ST_DONE
    } lt_state_t;

    localparam logic [1:0] LT_POS_TOPLEFT     = 2'd0;
    localparam logic [1:0] LT_POS_CENTER      = 2'd1;
    localparam logic [1:0] LT_POS_BOTTOMRIGHT = 2'd2;

    localparam int LT_US_DIV       = 27;
    localparam int LT_DEBOUNCE_CYC = 64;

    localparam logic [15:0] LT_RESULT_MAX = 16'hFFFF;
    localparam logic [7:0]  LT_FRAMES_MAX = 8'hFF;

endpackage

// File: rtl/lt_sensor_filter.sv
// lt_sensor_filter: 2-flop synchronizer for the photodiode comparator, followed by an
// optional hold-time debounce built only when LT_SENSOR_DEBOUNCE_EN is defined.
module lt_sensor_filter
    import lt_measure_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sensor,
    output logic o_sens_f
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sensor;
            r_sync2 <= r_sync1;
        end
    end

`ifdef LT_SENSOR_DEBOUNCE_EN
    localparam int CW = $clog2(LT_DEBOUNCE_CYC);

    logic          r_sens;
    logic [CW-1:0] r_cnt;

    // The counter tracks consecutive cycles of disagreement; any agreement restarts it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sens <= 1'b0;
            r_cnt  <= '0;
        end else if (r_sync2 == r_sens) begin
            r_cnt  <= '0;
        end else if (r_cnt == CW'(LT_DEBOUNCE_CYC - 1)) begin
            r_sens <= r_sync2;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_sens_f = r_sens;
`else
    assign o_sens_f = r_sync2;
`endif

endmodule

// File: rtl/lt_measure.sv
// lt_measure: display input-lag tester; times from the first VSYNC fall after arming to the
// photodiode seeing the box. Optional sensor debounce via LT_SENSOR_DEBOUNCE_EN.
module lt_measure
    import lt_measure_pkg::*;
#(
    parameter int P_US_DIV = LT_US_DIV
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic        trigger,
    input  logic [1:0]  mode_in,
    input  logic        VSYNC_in,
    input  logic        sensor,
    output logic        lt_active,
    output logic [1:0]  lt_mode,
    output logic [15:0] lt_result,
    output logic [7:0]  lt_frames,
    output logic        lt_finished
);

    logic        w_sens_f;
    logic        w_vs_fall;
    logic        w_trig_rise;
    logic        w_wrap;
    logic        w_counting;
    logic        r_vs_prev;
    logic        r_trig_prev;
    lt_state_t   r_state;
    lt_state_t   w_next;
    logic [4:0]  r_presc;
    logic [15:0] r_result;
    logic [7:0]  r_frames;
    logic [1:0]  r_mode;
    logic        r_active;
    logic        r_finished;

    lt_sensor_filter u_filter (
        .i_clk    (clk27),
        .i_rst_n  (reset_n),
        .i_sensor (sensor),
        .o_sens_f (w_sens_f)
    );

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_prev   <= 1'b0;
            r_trig_prev <= 1'b0;
        end else begin
            r_vs_prev   <= VSYNC_in;
            r_trig_prev <= trigger;
        end
    end

    assign w_vs_fall   = r_vs_prev & ~VSYNC_in;
    assign w_trig_rise = trigger & ~r_trig_prev;

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Abort (trigger low) is tested before detection so it wins a same-cycle tie.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_trig_rise) w_next = ST_ARM;
            ST_ARM:     w_next = !trigger ? ST_IDLE : (!w_sens_f ? ST_WAIT_VS : ST_ARM);
            ST_WAIT_VS: w_next = !trigger ? ST_IDLE : (w_vs_fall ? ST_MEASURE : ST_WAIT_VS);
            ST_MEASURE: w_next = !trigger ? ST_IDLE :
                                 ((w_sens_f || r_result == LT_RESULT_MAX) ? ST_DONE : ST_MEASURE);
            ST_DONE:    if (!trigger) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    assign w_wrap     = r_presc == 5'(P_US_DIV - 1);
    assign w_counting = (r_state == ST_MEASURE) && (w_next == ST_MEASURE);

    // Only cycles that stay in MEASURE advance time, so a wrap on the exit cycle is dropped.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_presc    <= '0;
            r_result   <= '0;
            r_frames   <= '0;
            r_mode     <= '0;
            r_active   <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            r_active   <= w_next == ST_MEASURE;
            r_finished <= w_next == ST_DONE;
            if (r_state == ST_IDLE && w_next == ST_ARM) begin
                r_presc  <= '0;
                r_result <= '0;
                r_frames <= '0;
                r_mode   <= mode_in;
            end else if (w_counting) begin
                r_presc <= w_wrap ? 5'd0 : r_presc + 5'd1;
                if (w_wrap && r_result != LT_RESULT_MAX) r_result <= r_result + 16'd1;
            end
            if (r_state == ST_MEASURE && w_vs_fall && r_frames != LT_FRAMES_MAX)
                r_frames <= r_frames + 8'd1;
        end
    end

    assign lt_active   = r_active;
    assign lt_mode     = r_mode;
    assign lt_result   = r_result;
    assign lt_frames   = r_frames;
    assign lt_finished = r_finished;

endmodule
